// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: replays A/B/index waveforms of a real encoder for
// commanded signed edge counts at a programmable edge period, tracking shaft position.
module quad_encoder_emulator #(
  parameter int CPR   = 2048,
  parameter int CNT_W = 32,
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_delta,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  input  logic             zero_pos,
  output logic             encoder_a,
  output logic             encoder_b,
  output logic             encoder_index,
  output logic [CNT_W-1:0] position,
  output logic             busy,
  output logic             done
);

  localparam int REV_W = $clog2(CPR);
  localparam logic [REV_W-1:0] REV_LAST = REV_W'(CPR - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state, w_nextState;
  logic [1:0]       r_phase, w_phaseNext;
  logic [CNT_W-1:0] r_pos, w_posNext;
  logic [REV_W-1:0] r_rev, w_revNext;
  logic [CNT_W-1:0] r_remaining;
  logic [PER_W-1:0] r_per, r_timer, w_timerNext;
  logic             r_dir;
  logic             r_a, r_b, r_index, r_done;
  logic             w_accept, w_step, w_finish, w_deltaZero;
  logic [CNT_W-1:0] w_deltaAbs;
  logic [PER_W-1:0] w_perClamped;

  assign w_deltaZero  = (cmd_delta == '0);
  assign w_deltaAbs   = cmd_delta[CNT_W-1] ? (~cmd_delta + CNT_W'(1)) : cmd_delta;
  assign w_perClamped = (cmd_period == '0) ? PER_W'(1) : cmd_period;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // Abort is checked before the step so it wins even on the final edge.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_timerNext = r_timer;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          if (!w_deltaZero) begin
            w_nextState = RUN;
            w_timerNext = '0;
          end
        end
      end
      RUN: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (r_timer == r_per - PER_W'(1)) begin
          w_step      = 1'b1;
          w_timerNext = '0;
          if (r_remaining == CNT_W'(1)) begin
            w_nextState = IDLE;
            w_finish    = 1'b1;
          end
        end else begin
          w_timerNext = r_timer + PER_W'(1);
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // rev counter wraps explicitly so CPR need not be a power of two.
  always_comb begin
    w_phaseNext = r_phase;
    w_posNext   = r_pos;
    w_revNext   = r_rev;
    if (w_step) begin
      if (!r_dir) begin
        w_phaseNext = r_phase + 2'd1;
        w_posNext   = r_pos + CNT_W'(1);
        w_revNext   = (r_rev == REV_LAST) ? '0 : r_rev + REV_W'(1);
      end else begin
        w_phaseNext = r_phase - 2'd1;
        w_posNext   = r_pos - CNT_W'(1);
        w_revNext   = (r_rev == '0) ? REV_LAST : r_rev - REV_W'(1);
      end
    end else if (zero_pos && (r_state == IDLE)) begin
      w_phaseNext = '0;
      w_posNext   = '0;
      w_revNext   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase     <= '0;
      r_pos       <= '0;
      r_rev       <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_index     <= 1'b1;
      r_done      <= 1'b0;
      r_timer     <= '0;
      r_per       <= PER_W'(1);
      r_remaining <= '0;
      r_dir       <= 1'b0;
    end else begin
      r_phase <= w_phaseNext;
      r_pos   <= w_posNext;
      r_rev   <= w_revNext;
      r_a     <= w_phaseNext[1] ^ w_phaseNext[0];
      r_b     <= w_phaseNext[1];
      r_index <= (w_revNext == '0);
      r_done  <= w_finish | (w_accept & w_deltaZero);
      r_timer <= w_timerNext;
      if (w_accept) begin
        r_remaining <= w_deltaAbs;
        r_dir       <= cmd_delta[CNT_W-1];
        r_per       <= w_perClamped;
      end else if (w_step) begin
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  assign encoder_a     = r_a;
  assign encoder_b     = r_b;
  assign encoder_index = r_index;
  assign position      = r_pos;
  assign busy          = (r_state == RUN);
  assign cmd_ready     = (r_state == IDLE);
  assign done          = r_done;

endmodule
